// File: rtl/bus_copy_master_pkg.sv
// Shared types and constants for the bus copy master
// and the bus/memory environment around it.
package bus_copy_master_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 64;
   localparam int LW_DEF = 8;

   localparam logic [15:0] S0_BASE = 16'h0000;
   localparam logic [15:0] S1_BASE = 16'h7000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

endpackage

// File: rtl/bus_copy_master_addr_gen.sv
// Source/destination word pointers and remaining count
// for one copy; exposes next values so outputs stay registered.
module bus_copy_master_addr_gen
   import bus_copy_master_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] src_in,
   input  logic [AW-1:0] dst_in,
   input  logic [LW-1:0] len_in,
   output logic [AW-1:0] src_nxt,
   output logic [AW-1:0] dst_nxt,
   output logic          last
);

   logic [AW-1:0] src_q, dst_q;
   logic [LW-1:0] rem_q, rem_d;

   // load on accept, advance one word per completed write
   always_comb begin
      src_nxt = src_q;
      dst_nxt = dst_q;
      rem_d   = rem_q;
      if (load) begin
         src_nxt = src_in;
         dst_nxt = dst_in;
         rem_d   = len_in;
      end else if (step) begin
         src_nxt = src_q + AW'(1);
         dst_nxt = dst_q + AW'(1);
         rem_d   = rem_q - LW'(1);
      end
   end

   assign last = (rem_q == LW'(1));

   // pointer and count registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         src_q <= '0;
         dst_q <= '0;
         rem_q <= '0;
      end else begin
         src_q <= src_nxt;
         dst_q <= dst_nxt;
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/bus_copy_master.sv
// Word-by-word memory copy engine owning one bus master
// port: read a word, write it, repeat while holding the request.
module bus_copy_master
   import bus_copy_master_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   input  logic          m_grant,
   input  logic [DW-1:0] m_din,
   output logic          m_req,
   output logic          m_wr,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_dout
);

   state_e        state_q, state_d;
   logic [DW-1:0] buf_q, buf_d;
   logic          m_req_q, m_req_d;
   logic          m_wr_q, m_wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_dout_q, m_dout_d;
   logic          load, step, last;
   logic [AW-1:0] src_nxt, dst_nxt;

   bus_copy_master_addr_gen #(
      .AW(AW),
      .LW(LW)
   ) u_addr_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .step    (step),
      .src_in  (src_addr),
      .dst_in  (dst_addr),
      .len_in  (len),
      .src_nxt (src_nxt),
      .dst_nxt (dst_nxt),
      .last    (last)
   );

   // next state, plus outputs decoded from the state being entered
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      load    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  load    = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            if (m_grant) state_d = ST_RD;
         end
         ST_RD: begin
            state_d = m_grant ? ST_CAP : ST_REQ;
         end
         ST_CAP: begin
            if (m_grant) begin
               buf_d   = m_din;
               state_d = ST_WR;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WR: begin
            if (m_grant) begin
               step    = 1'b1;
               state_d = last ? ST_DONE : ST_RD;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      m_req_d  = (state_d == ST_REQ) || (state_d == ST_RD) ||
                 (state_d == ST_CAP) || (state_d == ST_WR);
      m_wr_d   = (state_d == ST_WR);
      busy_d   = m_req_d;
      done_d   = (state_d == ST_DONE);
      m_addr_d = '0;
      if (m_wr_d)       m_addr_d = dst_nxt;
      else if (m_req_d) m_addr_d = src_nxt;
      m_dout_d = m_wr_d ? buf_d : '0;
   end

   // state, buffer and registered bus/status outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         buf_q    <= '0;
         m_req_q  <= 1'b0;
         m_wr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         m_addr_q <= '0;
         m_dout_q <= '0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         m_req_q  <= m_req_d;
         m_wr_q   <= m_wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         m_addr_q <= m_addr_d;
         m_dout_q <= m_dout_d;
      end
   end

   assign m_req  = m_req_q;
   assign m_wr   = m_wr_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign m_addr = m_addr_q;
   assign m_dout = m_dout_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: bus/RAM model, per-cycle
// expected-trace model, and directed copy scenarios.
module tb_bus_copy_master;
   import bus_copy_master_pkg::*;

   localparam int AW = 16;
   localparam int DW = 64;
   localparam int LW = 8;

   localparam int K_REQ  = 0;
   localparam int K_RD   = 1;
   localparam int K_CAP  = 2;
   localparam int K_WR   = 3;
   localparam int K_DONE = 4;
   localparam int K_IDLE = 5;

   typedef struct {
      int          kind;
      logic [15:0] src;
      logic [15:0] dst;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset_n, start, m_grant;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] len;
   logic          busy, done, m_req, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_dout;
   logic [DW-1:0] m_din = '0;

   int errs = 0;
   int checks = 0;

   logic [DW-1:0] mem     [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   bit            mem_ld = 1'b0;
   bit            ref_ld = 1'b0;
   bit            chk_en = 1'b0;

   ent_t          q[$];
   ent_t          e;
   bit            act;
   logic [15:0]   s16, d16;
   logic [15:0]   wr_seen[$];
   logic [3:0]    exp_ctl;

   int done_cyc, wr_cnt, req_cnt;

   always #5 clk = ~clk;

   bus_copy_master #(
      .AW(AW),
      .DW(DW),
      .LW(LW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .m_grant  (m_grant),
      .m_din    (m_din),
      .m_req    (m_req),
      .m_wr     (m_wr),
      .m_addr   (m_addr),
      .m_dout   (m_dout)
   );

   function automatic logic [DW-1:0] init_val(int a);
      if (a < 4) return 64'(a + 1);
      if (a == 65535) return 64'hDEAD_BEEF_0000_FFFF;
      return '0;
   endfunction

   task automatic chk(string nm, logic [63:0] act_v, logic [63:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   // BUS + RAMs: granted read returns data next cycle, granted write stores
   always @(posedge clk) begin
      if (!mem_ld) begin
         for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
         mem_ld = 1'b1;
      end
      if (m_req && m_grant) begin
         if (m_wr) mem[m_addr] = m_dout;
         else      m_din <= mem[m_addr];
      end
   end

   // reference model: expected per-cycle bus activity as a queue
   always @(negedge clk) begin
      if (!ref_ld) begin
         for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
         ref_ld = 1'b1;
      end
      if (chk_en) begin
         act = (q.size() > 0);
         if (act) e = q.pop_front();
         else     e = '{K_IDLE, 16'h0, 16'h0};
         exp_ctl = {e.kind <= K_WR, e.kind == K_WR,
                    e.kind <= K_WR, e.kind == K_DONE};
         chk("ctl", {60'h0, m_req, m_wr, busy, done}, {60'h0, exp_ctl});
         if (e.kind == K_RD || e.kind == K_CAP)
            chk("rd_addr", 64'(m_addr), 64'(e.src));
         if (e.kind == K_WR) begin
            chk("wr_addr", 64'(m_addr), 64'(e.dst));
            chk("wr_data", m_dout, ref_mem[e.src]);
            if (m_grant) ref_mem[e.dst] = ref_mem[e.src];
         end
         if (!reset_n) begin
            q.delete();
         end else if (e.kind <= K_WR && !m_grant) begin
            if (e.kind == K_RD) begin
               q.delete(0);
               q.delete(0);
            end else if (e.kind == K_CAP) begin
               q.delete(0);
            end
            if (e.kind != K_REQ) begin
               q.push_front('{K_WR, e.src, e.dst});
               q.push_front('{K_CAP, e.src, e.dst});
               q.push_front('{K_RD, e.src, e.dst});
            end
            q.push_front('{K_REQ, e.src, e.dst});
         end else if (e.kind == K_IDLE && start) begin
            if (len == '0) begin
               q.push_back('{K_DONE, 16'h0, 16'h0});
            end else begin
               q.push_back('{K_REQ, src_addr, dst_addr});
               for (int w = 0; w < int'(len); w++) begin
                  s16 = 16'(int'(src_addr) + w);
                  d16 = 16'(int'(dst_addr) + w);
                  q.push_back('{K_RD, s16, d16});
                  q.push_back('{K_CAP, s16, d16});
                  q.push_back('{K_WR, s16, d16});
               end
               q.push_back('{K_DONE, 16'h0, 16'h0});
            end
         end
      end
   end

   task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                           input logic [7:0] n, input int stall_at,
                           input int stall_n, input int rst_at,
                           input int max_cyc);
      @(posedge clk); #1;
      src_addr = s;
      dst_addr = d;
      len      = n;
      start    = 1'b1;
      done_cyc = 0;
      wr_cnt   = 0;
      req_cnt  = 0;
      wr_seen.delete();
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk); #1;
         start   = 1'b0;
         m_grant = !(c >= stall_at && c < stall_at + stall_n);
         reset_n = (c != rst_at);
         @(negedge clk);
         if (c == rst_at + 1)
            chk("mid_reset_outs",
                {43'h0, m_req, m_wr, busy, done, m_addr}, 64'h0);
         if (m_wr) begin
            wr_cnt++;
            wr_seen.push_back(m_addr);
         end
         if (m_req) req_cnt++;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      @(posedge clk); #1;
      m_grant = 1'b1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      m_grant  = 1'b1;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;

      // reset held for two cycles
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {43'h0, m_req, m_wr, busy, done, m_addr}, 64'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // four-word copy s0 -> s1
      run_copy(16'h0000, 16'h7000, 8'd4, -1, 0, -1, 40);
      chk("s2_done_cyc", 64'(done_cyc), 64'd14);
      chk("s2_wr_cnt", 64'(wr_cnt), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("s2_s1_word", mem[16'h7000 + i], 64'(i + 1));

      // zero-length start
      run_copy(16'h0100, 16'h7100, 8'd0, -1, 0, -1, 10);
      chk("s3_done_cyc", 64'(done_cyc), 64'd1);
      chk("s3_req_cnt", 64'(req_cnt), 64'd0);

      // source address wraps FFFF -> 0000
      run_copy(16'hFFFF, 16'h7010, 8'd2, -1, 0, -1, 20);
      chk("s4_done_cyc", 64'(done_cyc), 64'd8);
      chk("s4_wr_n", 64'(wr_seen.size()), 64'd2);
      if (wr_seen.size() == 2) begin
         chk("s4_wr0_addr", 64'(wr_seen[0]), 64'h7010);
         chk("s4_wr1_addr", 64'(wr_seen[1]), 64'h7011);
      end
      chk("s4_mem7010", mem[16'h7010], 64'hDEAD_BEEF_0000_FFFF);
      chk("s4_mem7011", mem[16'h7011], 64'h1);

      // grant dropped for three cycles during word 2 capture
      run_copy(16'h0000, 16'h7000, 8'd4, 6, 3, -1, 40);
      chk("s5_done_cyc", 64'(done_cyc), 64'd19);
      chk("s5_wr_cnt", 64'(wr_cnt), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("s5_s1_word", mem[16'h7000 + i], 64'(i + 1));

      // reset during word 2 write, then a clean rerun
      run_copy(16'h0000, 16'h7020, 8'd4, -1, 0, 7, 20);
      chk("s6_no_done", 64'(done_cyc), 64'd0);
      run_copy(16'h0000, 16'h7020, 8'd4, -1, 0, -1, 40);
      chk("s6_rerun_done", 64'(done_cyc), 64'd14);
      for (int i = 0; i < 4; i++)
         chk("s6_s1_word", mem[16'h7020 + i], 64'(i + 1));

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
